calendar_clock_core: RTL

Parametrised BCD timekeeper: seconds, minutes, hours, day-of-month and month, advanced by an internal prescaler with normal and fast rates. Successor to the fixed day-only counter. Adds:
- a month field with a true month-length table, including leap-year February;
- optional 12-hour display with PM flag;
- validated loading;
- carry/tick pulses for downstream alarm and display logic.

It sits between the set-mode UI block and the 7-segment display drivers.

---
 rtl/calendar_clock_core_if.sv | 29 ++
 rtl/calendar_clock_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/calendar_clock_core_if.sv
// Set-mode UI / display-driver side of the calendar clock core.
// Load digits and mode controls flow in; BCD time/date and event pulses flow out.
interface calendar_clock_core_if;
  logic       SET;
  logic       FAST;
  logic       LEAP;
  logic       MODE12;
  logic [3:0] SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1;
  logic [3:0] SDAY0, SDAY1, SMON0, SMON1;
  logic [3:0] SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1;
  logic [3:0] DAY0, DAY1, MON0, MON1;
  logic       PM;
  logic       TICK;
  logic       DAY_ROLL;

  modport master (
    output SET, FAST, LEAP, MODE12,
    output SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1, SMON0, SMON1,
    input  SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1, DAY0, DAY1, MON0, MON1,
    input  PM, TICK, DAY_ROLL
  );

  modport slave (
    input  SET, FAST, LEAP, MODE12,
    input  SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1, SMON0, SMON1,
    output SEC0, SEC1, MIN0, MIN1, HOUR0, HOUR1, DAY0, DAY1, MON0, MON1,
    output PM, TICK, DAY_ROLL
  );
endinterface

// File: rtl/calendar_clock_core.sv
// BCD seconds/minutes/hours/day/month timekeeper with leap-aware month lengths,
// validated loading, optional 12-hour presentation and tick/day-roll pulses.
module calendar_clock_core #(
  parameter int CNT_W      = 16,
  parameter int DIV_NORMAL = 5000,
  parameter int DIV_FAST   = 50
) (
  input logic                  CLK,
  input logic                  RST,
  calendar_clock_core_if.slave bus
);

  localparam logic [CNT_W-1:0] LIM_NORMAL = CNT_W'(DIV_NORMAL - 1);
  localparam logic [CNT_W-1:0] LIM_FAST   = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Fields are packed BCD {tens, units}, so numeric compares work directly.
  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    digits_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] ms_load(input logic [7:0] v);
    ms_load = (digits_ok(v) && (v[7:4] <= 4'd5)) ? v : 8'h00;
  endfunction

  function automatic logic [7:0] hour_load(input logic [7:0] v);
    hour_load = (digits_ok(v) && (v <= 8'h23)) ? v : 8'h00;
  endfunction

  function automatic logic [7:0] mon_load(input logic [7:0] v);
    mon_load = (digits_ok(v) && (v != 8'h00) && (v <= 8'h12)) ? v : 8'h01;
  endfunction

  function automatic logic [7:0] day_load(input logic [7:0] v, input logic [7:0] mon,
                                          input logic leap);
    day_load = (digits_ok(v) && (v != 8'h00) && (v <= month_len(mon, leap))) ? v : 8'h01;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       sec_r, min_r, hour_r, day_r, mon_r;
  logic             tick_r, roll_r;

  logic [CNT_W-1:0] div_lim_s;
  logic [7:0]       ld_sec_s, ld_min_s, ld_hour_s, ld_mon_s, ld_day_s;
  logic             carry_min_s, carry_hour_s, carry_day_s;
  logic [4:0]       hour_bin_s, h12_s;
  logic [7:0]       disp_hour_s;
  logic             pm_s;

  // Rate selection, validated load values and the seconds carry chain.
  always_comb begin
    div_lim_s    = bus.FAST ? LIM_FAST : LIM_NORMAL;
    ld_sec_s     = ms_load({bus.SSEC1, bus.SSEC0});
    ld_min_s     = ms_load({bus.SMIN1, bus.SMIN0});
    ld_hour_s    = hour_load({bus.SHOUR1, bus.SHOUR0});
    ld_mon_s     = mon_load({bus.SMON1, bus.SMON0});
    ld_day_s     = day_load({bus.SDAY1, bus.SDAY0}, ld_mon_s, bus.LEAP);
    carry_min_s  = (sec_r == 8'h59);
    carry_hour_s = carry_min_s && (min_r == 8'h59);
    carry_day_s  = carry_hour_s && (hour_r == 8'h23);
  end

  // Timekeeping registers: reset, level-sensitive load, then prescaled counting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r  <= '0;
      sec_r  <= 8'h00;
      min_r  <= 8'h00;
      hour_r <= 8'h00;
      day_r  <= 8'h01;
      mon_r  <= 8'h01;
      tick_r <= 1'b0;
      roll_r <= 1'b0;
    end else if (bus.SET) begin
      cnt_r  <= '0;
      sec_r  <= ld_sec_s;
      min_r  <= ld_min_s;
      hour_r <= ld_hour_s;
      day_r  <= ld_day_s;
      mon_r  <= ld_mon_s;
      tick_r <= 1'b0;
      roll_r <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      roll_r <= 1'b0;
      if (cnt_r == div_lim_s) begin
        cnt_r  <= '0;
        tick_r <= 1'b1;
        sec_r  <= carry_min_s ? 8'h00 : bcd_inc(sec_r);
        if (carry_min_s)  min_r  <= (min_r == 8'h59) ? 8'h00 : bcd_inc(min_r);
        if (carry_hour_s) hour_r <= (hour_r == 8'h23) ? 8'h00 : bcd_inc(hour_r);
        // A day above the current limit (LEAP dropped on Feb 29) also rolls over.
        if (carry_day_s) begin
          roll_r <= 1'b1;
          if (day_r >= month_len(mon_r, bus.LEAP)) begin
            day_r <= 8'h01;
            mon_r <= (mon_r == 8'h12) ? 8'h01 : bcd_inc(mon_r);
          end else begin
            day_r <= bcd_inc(day_r);
          end
        end
      end else if (cnt_r > div_lim_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // 12-hour presentation derived from the 24-hour register; stored state untouched.
  always_comb begin
    hour_bin_s  = ({1'b0, hour_r[7:4]} * 5'd10) + {1'b0, hour_r[3:0]};
    h12_s       = hour_bin_s - 5'd12;
    disp_hour_s = hour_r;
    pm_s        = 1'b0;
    if (bus.MODE12) begin
      if (hour_r == 8'h00) begin
        disp_hour_s = 8'h12;
        pm_s        = 1'b0;
      end else if (hour_r < 8'h12) begin
        disp_hour_s = hour_r;
        pm_s        = 1'b0;
      end else if (hour_r == 8'h12) begin
        disp_hour_s = 8'h12;
        pm_s        = 1'b1;
      end else begin
        pm_s = 1'b1;
        if (h12_s >= 5'd10) disp_hour_s = {4'd1, 4'(h12_s - 5'd10)};
        else                disp_hour_s = {4'd0, h12_s[3:0]};
      end
    end else begin
      disp_hour_s = hour_r;
      pm_s        = 1'b0;
    end
  end

  assign bus.SEC0     = sec_r[3:0];
  assign bus.SEC1     = sec_r[7:4];
  assign bus.MIN0     = min_r[3:0];
  assign bus.MIN1     = min_r[7:4];
  assign bus.HOUR0    = disp_hour_s[3:0];
  assign bus.HOUR1    = disp_hour_s[7:4];
  assign bus.DAY0     = day_r[3:0];
  assign bus.DAY1     = day_r[7:4];
  assign bus.MON0     = mon_r[3:0];
  assign bus.MON1     = mon_r[7:4];
  assign bus.PM       = pm_s;
  assign bus.TICK     = tick_r;
  assign bus.DAY_ROLL = roll_r;

endmodule
